// File: rtl/alu_sequencer_pkg.sv
// alu_pkg: opcodes, FSM state encoding and opcode latency for the ALU sequencer
// Contents: alu_op_t and OP_* constants, state_t (IDLE/EXEC/RESP),
//   op_latency(op, mul, div) giving the settle time L of an opcode.
package alu_pkg;
    typedef logic [3:0] alu_op_t;
    localparam alu_op_t OP_AND  = 4'b0000;
    localparam alu_op_t OP_OR   = 4'b0001;
    localparam alu_op_t OP_XOR  = 4'b0010;
    localparam alu_op_t OP_NOT  = 4'b0011;
    localparam alu_op_t OP_ADD  = 4'b0100;
    localparam alu_op_t OP_SUB  = 4'b0101;
    localparam alu_op_t OP_SLL  = 4'b0110;
    localparam alu_op_t OP_SRL  = 4'b0111;
    localparam alu_op_t OP_SRA  = 4'b1000;
    localparam alu_op_t OP_SLT  = 4'b1001;
    localparam alu_op_t OP_SLTU = 4'b1010;
    localparam alu_op_t OP_MUL  = 4'b1011;
    localparam alu_op_t OP_DIV  = 4'b1100;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    function automatic int unsigned op_latency(alu_op_t op, int unsigned mul, int unsigned div);
        return op == OP_MUL ? mul : op == OP_DIV ? div : 1;
    endfunction
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request, ALU and response channels of the ALU sequencer
// slave modport: the sequencer (drives ready, alu_*, rsp_*, busy)
// master modport: requesters, ALU and response consumer
interface alu_sequencer_if #(parameter int DATA_W = 32);
    logic              req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]        req0_op, req1_op;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic [3:0]        alu_op;
    logic              rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [DATA_W-1:0] rsp_data;

    modport slave (
        input  req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
               alu_result, rsp_ready,
        output req0_ready, req1_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_data,
               rsp_err, busy
    );
    modport master (
        output req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
               alu_result, rsp_ready,
        input  req0_ready, req1_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_data,
               rsp_err, busy
    );
endinterface

// File: rtl/alu_sequencer_rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin grant, remembers the last winner
// Ports: clk, rst_n (async, active-low), en (grants allowed), valid[1:0], grant[1:0]
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);
    logic last_grant;
    logic pick1;

    // On a tie, the requester that did not win last time goes next.
    assign pick1 = valid[1] & (~valid[0] | ~last_grant);
    assign grant = en ? {pick1, valid[0] & ~pick1} : 2'b00;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            last_grant <= 1'b1;
        else if (|grant)
            last_grant <= grant[1];
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: shares one combinational ALU between two requesters, multi-cycle settle
// Ports: clk, rst_n (async, active-low), bus (alu_sequencer_if.slave: req0/req1 valid-ready,
//   registered alu_a/alu_b/alu_op, alu_result in, rsp valid-ready with id/data/err, busy)
// Optional: ALU_SEQ_DIV_ZERO_CHECK_EN short-circuits div-by-zero to an all-ones error response.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input logic            clk,
    input logic            rst_n,
    alu_sequencer_if.slave bus
);
    localparam int CW = $clog2(MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES) + 1;

    state_t            state, state_n;
    logic [CW-1:0]     cnt;
    logic [1:0]        grant;
    logic              sel, dz_in, dz, illegal;
    alu_op_t           op_in;
    logic [DATA_W-1:0] a_in, b_in;
    int unsigned       lat;

    rr_arbiter_2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == IDLE),
        .valid ({bus.req1_valid, bus.req0_valid}),
        .grant (grant)
    );

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign bus.rsp_valid  = state == RESP;
    assign bus.busy       = state != IDLE;

    assign sel     = grant[1];
    assign op_in   = sel ? bus.req1_op : bus.req0_op;
    assign a_in    = sel ? bus.req1_a : bus.req0_a;
    assign b_in    = sel ? bus.req1_b : bus.req0_b;
    assign illegal = bus.alu_op > OP_DIV;
`ifdef ALU_SEQ_DIV_ZERO_CHECK_EN
    assign dz_in = op_in == OP_DIV && b_in == '0;
`else
    assign dz_in = 1'b0;
`endif
    assign lat = dz_in ? 1 : op_latency(op_in, MUL_CYCLES, DIV_CYCLES);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_n;

    always_comb begin
        state_n = state;
        if (state == IDLE)
            state_n = |grant ? EXEC : IDLE;
        else if (state == EXEC)
            state_n = cnt == '0 ? RESP : EXEC;
        else
            state_n = bus.rsp_ready ? IDLE : RESP;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt          <= '0;
            dz           <= 1'b0;
            bus.alu_a    <= '0;
            bus.alu_b    <= '0;
            bus.alu_op   <= '0;
            bus.rsp_id   <= 1'b0;
            bus.rsp_data <= '0;
            bus.rsp_err  <= 1'b0;
        end else begin
            if (|grant) begin
                bus.alu_a  <= a_in;
                bus.alu_b  <= b_in;
                bus.alu_op <= op_in;
                bus.rsp_id <= sel;
                dz         <= dz_in;
                cnt        <= CW'(lat - 1);
            end else if (state == EXEC && cnt != '0)
                cnt <= cnt - CW'(1);
            if (state == EXEC && cnt == '0) begin
                bus.rsp_data <= illegal ? '0 : dz ? '1 : bus.alu_result;
                bus.rsp_err  <= illegal | dz;
            end
        end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench for alu_sequencer with a stub ALU
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    alu_sequencer_if #(.DATA_W(32)) bus ();

    alu_sequencer #(.DATA_W(32), .MUL_CYCLES(4), .DIV_CYCLES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.alu_result = bus.alu_a ^ bus.alu_b;
        case (bus.alu_op)
            4'b0000: bus.alu_result = bus.alu_a & bus.alu_b;
            4'b0001: bus.alu_result = bus.alu_a | bus.alu_b;
            4'b0100: bus.alu_result = bus.alu_a + bus.alu_b;
            4'b0101: bus.alu_result = bus.alu_a - bus.alu_b;
            4'b1011: bus.alu_result = bus.alu_a * bus.alu_b;
            4'b1100: bus.alu_result = bus.alu_b == 0 ? 32'hDEAD_BEEF : bus.alu_a / bus.alu_b;
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input bit id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int k;
        @(negedge clk);
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
        #1;
        for (k = 0; k < 50 && !(id ? bus.req1_ready : bus.req0_ready); k++) begin
            @(negedge clk);
            #1;
        end
        if (k == 50) check("issue_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    logic op_changed;

    task automatic wait_rsp(output int n);
        logic [3:0] hold;
        hold = bus.alu_op;
        op_changed = 1'b0;
        n = 0;
        while (!bus.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
            if (bus.alu_op !== hold) op_changed = 1'b1;
        end
        if (n == 50) check("rsp_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, span, bl;
        int g[$];
        logic ok;
        bus.req0_valid = 0; bus.req1_valid = 0; bus.rsp_ready = 1;
        bus.req0_op = 0; bus.req1_op = 0;
        bus.req0_a = 0; bus.req0_b = 0; bus.req1_a = 0; bus.req1_b = 0;
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_alu_a", bus.alu_a, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        rst_n = 1'b1;

        issue(0, 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
        check("and_busy", bus.busy, 1);
        check("and_alu_a", bus.alu_a, 32'hF0F0_F0F0);
        check("and_alu_b", bus.alu_b, 32'hFF00_FF00);
        wait_rsp(n);
        check("and_lat", n, 1);
        check("and_data", bus.rsp_data, 32'hF000_F000);
        check("and_id", bus.rsp_id, 0);
        check("and_err", bus.rsp_err, 0);

        issue(1, 4'b1011, 32'd3, 32'd5);
        wait_rsp(n);
        check("mul_lat", n, 4);
        check("mul_op_stable", op_changed, 0);
        check("mul_op", bus.alu_op, 4'b1011);
        check("mul_data", bus.rsp_data, 15);
        check("mul_id", bus.rsp_id, 1);

        bus.req0_op = 4'b0001; bus.req0_a = 1; bus.req0_b = 2;
        bus.req1_op = 4'b0001; bus.req1_a = 4; bus.req1_b = 8;
        bus.req0_valid = 1; bus.req1_valid = 1;
        span = 0; bl = 0;
        for (int c = 0; c < 40 && g.size() < 4; c++) begin
            @(negedge clk);
            #1;
            if (bus.req0_ready) g.push_back(0);
            if (bus.req1_ready) g.push_back(1);
            if (g.size() > 0) begin
                span++;
                if (!bus.busy) bl++;
            end
            if (bus.rsp_valid) check("rr_data", bus.rsp_data, bus.rsp_id ? 12 : 3);
        end
        @(posedge clk);
        @(negedge clk);
        bus.req0_valid = 0; bus.req1_valid = 0;
        while (g.size() < 4) g.push_back(2);
        check("rr_g0", g[0], 0);
        check("rr_g1", g[1], 1);
        check("rr_g2", g[2], 0);
        check("rr_g3", g[3], 1);
        check("rr_span", span, 10);
        check("rr_busy_low", bl, 4);
        wait_rsp(n);
        check("rr_last_data", bus.rsp_data, 12);
        check("rr_last_id", bus.rsp_id, 1);

        issue(0, 4'b1110, 32'd7, 32'd9);
        wait_rsp(n);
        check("ill_lat", n, 1);
        check("ill_data", bus.rsp_data, 0);
        check("ill_err", bus.rsp_err, 1);
        check("ill_id", bus.rsp_id, 0);
        @(negedge clk);

        bus.rsp_ready = 0;
        issue(1, 4'b0100, 32'd10, 32'd20);
        wait_rsp(n);
        check("hold_lat", n, 1);
        bus.req0_valid = 1; bus.req0_op = 4'b0000;
        repeat (5) begin
            @(negedge clk);
            #1;
            check("hold_valid", bus.rsp_valid, 1);
            check("hold_data", bus.rsp_data, 30);
            check("hold_id", bus.rsp_id, 1);
            check("hold_ready0", bus.req0_ready, 0);
            check("hold_ready1", bus.req1_ready, 0);
        end
        bus.rsp_ready = 1; bus.req0_valid = 0;
        @(negedge clk);
        #1;
        check("drop_busy", bus.busy, 0);
        check("drop_ready0", bus.req0_ready, 0);
        @(negedge clk);
        check("drop_not_served", bus.busy, 0);

        issue(0, 4'b1100, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        check("div_busy", bus.busy, 1);
        rst_n = 0;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_rsp_valid", bus.rsp_valid, 0);
        check("mid_rst_alu_a", bus.alu_a, 0);
        check("mid_rst_alu_b", bus.alu_b, 0);
        check("mid_rst_alu_op", bus.alu_op, 0);
        check("mid_rst_rsp_data", bus.rsp_data, 0);
        check("mid_rst_rsp_err", bus.rsp_err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        bus.req0_valid = 1; bus.req1_valid = 1;
        #1;
        check("tie_ready0", bus.req0_ready, 1);
        check("tie_ready1", bus.req1_ready, 0);
        bus.req0_valid = 0; bus.req1_valid = 0;
        ok = 1;
        repeat (10) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.busy) ok = 0;
        end
        check("rst_no_rsp", ok, 1);
        issue(1, 4'b0101, 32'd50, 32'd8);
        wait_rsp(n);
        check("post_lat", n, 1);
        check("post_data", bus.rsp_data, 42);
        check("post_id", bus.rsp_id, 1);
        check("post_err", bus.rsp_err, 0);

        issue(0, 4'b1100, 32'd5, 32'd0);
        wait_rsp(n);
`ifdef ALU_SEQ_DIV_ZERO_CHECK_EN
        check("dz_lat", n, 1);
        check("dz_data", bus.rsp_data, 32'hFFFF_FFFF);
        check("dz_err", bus.rsp_err, 1);
`else
        check("dz_lat", n, 8);
        check("dz_data", bus.rsp_data, 32'hDEAD_BEEF);
        check("dz_err", bus.rsp_err, 0);
`endif
        @(negedge clk);
        check("end_busy", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that shares the single combinational ALU between two requesters (instruction datapath and auxiliary unit). It arbitrates round-robin, holds the chosen operands and opcode stable on the ALU inputs for an opcode-dependent settle time, samples the ALU result, and returns it over a valid/ready response channel. It sits between the control unit and the ALU, and owns all timing of ALU operand and opcode changes.

## Interface
- `DATA_W`, 32: operand and result width.
- `MUL_CYCLES`, 4: settle cycles for opcode 4'b1011 (mul); must be ≥1.
- `DIV_CYCLES`, 8: settle cycles for opcode 4'b1100 (div); must be ≥1.
- `clk`  in  1  sole clock; rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `req0_op` / `req1_op`  in  4  ALU opcode.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  DATA_W  operands.
- `alu_a`, `alu_b`  out  DATA_W  ALU operands, registered.
- `alu_op`  out  4  ALU opcode, registered.
- `alu_result`  in  DATA_W  combinational ALU output.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_id`  out  1  requester index of response.
- `rsp_data`  out  DATA_W  sampled result.
- `rsp_err`  out  1  illegal opcode (or div-by-zero when enabled).
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: `reqN_ready` = grant to N. Only one ready is high per cycle, and only while that requester's valid is high. On handshake, latch op/a/b into the `alu_*` registers, latch id, load the counter with L−1, and go to EXEC.
- Arbitration: if only one requester is valid, it wins. If both are valid, the requester not granted last wins. `last_grant` resets to 1, so req0 wins the first tie.
- Latency L by opcode:
  - 0000–1010: L = 1.
  - 1011: L = MUL_CYCLES.
  - 1100: L = DIV_CYCLES.
  - 1101–1111 (illegal): L = 1.
- EXEC: decrement the counter. When the counter is 0, register `rsp_data` ← `alu_result` and go to RESP.
  - Illegal opcode: `rsp_data` ← 0 and `rsp_err` ← 1.
  - Otherwise `rsp_err` ← 0.
- RESP: `rsp_valid` = 1. `rsp_data`, `rsp_id` and `rsp_err` stay stable until `rsp_ready`. On handshake, go to IDLE.
- `alu_a`, `alu_b` and `alu_op` change only on a request handshake. They hold their last value otherwise, including in IDLE.
- Counter width is clog2(max(MUL_CYCLES, DIV_CYCLES)) + 1. No wrap: the counter is only decremented while nonzero.
- Reset, asynchronous and valid in any state, including mid-EXEC:
  - State → IDLE; counter → 0; `last_grant` → 1.
  - All outputs → 0.
  - An in-flight operation is discarded with no response.

## Timing
- Handshake at edge T → `alu_*` valid after T → result sampled at edge T+L → `rsp_valid` high after T+L.
- `reqN_ready` is combinational from state, `reqN_valid` and `last_grant`.
- No other output is combinational from inputs.
- Minimum issue interval: L+2 cycles when `rsp_ready` is held high. There is one IDLE cycle between operations.
- A requester that drops valid before being granted is not served.
- A request arriving during EXEC or RESP waits.

## Configuration
- `ALU_SEQ_DIV_ZERO_CHECK_EN`:
  - Defined: opcode 1100 with `req_b` == 0 takes L = 1. The response is `rsp_data` = all ones, `rsp_err` = 1, and the ALU result is ignored.
  - Undefined: div-by-zero runs the normal DIV_CYCLES path, with `rsp_err` = 0 and whatever the ALU produces.

## Structure
- Shared package `alu_pkg` holds:
  - Opcode constants (OP_AND = 4'b0000 … OP_DIV = 4'b1100) and an `alu_op_t` typedef.
  - The FSM state enum.
  - The `op_latency` function mapping opcode to L.
- One sub-module, `rr_arbiter_2`: 2-way round-robin grant logic holding `last_grant`.
- FSM, counter and output registers stay in `alu_sequencer`.

## Test plan
- Reset, then req0 op=0000, a=0xF0F0_F0F0, b=0xFF00_FF00, ALU stubbed to AND, `rsp_ready`=1 → `rsp_valid` 1 cycle after grant with `rsp_data`=0xF000_F000, `rsp_id`=0, `rsp_err`=0.
- req1 op=1011 with default MUL_CYCLES=4 → `rsp_valid` rises exactly 4 cycles after handshake. `alu_op`=1011 stays stable throughout.
- Both requesters valid continuously, op=0001:
  - Grants alternate 0,1,0,1 starting with 0.
  - `busy` is low exactly one cycle between operations.
- req0 op=1110 → `rsp_err`=1, `rsp_data`=0, L=1.
- `rsp_ready` held low for 5 cycles in RESP → `rsp_valid`/`rsp_data` stable, both ready signals low, and no new grant.
- Reset asserted 3 cycles into a DIV → all outputs 0 immediately with no response. Post-reset, req1 alone is served normally.
- With `ALU_SEQ_DIV_ZERO_CHECK_EN`: op=1100, b=0 → after 1 cycle, `rsp_data`=0xFFFF_FFFF, `rsp_err`=1.
